// File: rtl/text_lcd_pkg.sv
// Shared types and constants for the HD44780-style multi-row text LCD writer.
package text_lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLR_WAIT,
    ST_WAIT_REQ,
    ST_ADDR,
    ST_CHAR,
    ST_DONE
  } lcd_state_e;

  // One bus transaction as presented on LCD_RS/LCD_DATA
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_xfer_t;

  localparam int unsigned N_INIT_CMD = 4;
  localparam logic [7:0]  INIT_CMD [N_INIT_CMD] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  localparam logic [7:0]  CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0]  ROW_OFFSET [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  function automatic logic [7:0] row_addr_cmd(input logic [1:0] row);
    return CMD_SET_DDRAM | ROW_OFFSET[row];
  endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Times one LCD bus slot: setup, EN-high window and hold, with an end-of-slot strobe.
module lcd_slot_timer #(
  parameter int unsigned T_SU = 200,
  parameter int unsigned T_EN = 1600,
  parameter int unsigned T_HD = 200
) (
  input  logic LCDCLK,
  input  logic PRESETn,
  input  logic start,
  output logic active,
  output logic en,
  output logic slot_done
);

  localparam int unsigned SLOT  = T_SU + T_EN + T_HD;
  localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = CNT_W'(cnt + 1'b1);

  function automatic logic in_window(input logic [CNT_W-1:0] c);
    return (32'(c) >= T_SU) && (32'(c) < (T_SU + T_EN));
  endfunction

  // EN and slot_done are computed from the count the cycle will hold next
  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt       <= '0;
      active    <= 1'b0;
      en        <= 1'b0;
      slot_done <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      active    <= 1'b1;
      en        <= in_window(CNT_W'(0));
      slot_done <= (LAST == CNT_W'(0));
    end else if (active) begin
      if (cnt == LAST) begin
        cnt       <= '0;
        active    <= 1'b0;
        en        <= 1'b0;
        slot_done <= 1'b0;
      end else begin
        cnt       <= cnt_inc;
        en        <= in_window(cnt_inc);
        slot_done <= (cnt_inc == LAST);
      end
    end
  end

endmodule

// File: rtl/text_lcd_multi.sv
// Multi-row character LCD frame writer; snapshots a frame and streams it as timed bus slots.
// Define TEXT_LCD_INIT_SEQ_EN to send the controller init sequence after reset.
module text_lcd_multi
  import text_lcd_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned T_SU         = 200,
  parameter int unsigned T_EN         = 1600,
  parameter int unsigned T_HD         = 200,
  parameter int unsigned T_CLR        = 100000,
  parameter int unsigned AUTO_REFRESH = 1
) (
  input  logic                   LCDCLK,
  input  logic                   PRESETn,
  input  logic [8*COLS*ROWS-1:0] data,
  input  logic                   update_req,
  output logic                   update_ack,
  output logic                   busy,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic                   LCD_EN,
  output logic [7:0]             LCD_DATA
);

  localparam int unsigned N_CHARS = COLS * ROWS;
  localparam int unsigned IDX_W   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CLR_W   = (T_CLR > 1) ? $clog2(T_CLR) : 1;

`ifdef TEXT_LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  lcd_state_e                 state;
  lcd_xfer_t                  xfer;
  logic [N_CHARS-1:0][7:0]    frame;
  logic [1:0]                 init_idx;
  logic [ROW_W-1:0]           row_idx;
  logic [COL_W-1:0]           col_idx;
  logic [IDX_W-1:0]           char_idx;
  logic [CLR_W-1:0]           clr_cnt;
  logic                       slot_active;
  logic                       slot_en;
  logic                       slot_done;
  logic                       launch_c;

  lcd_slot_timer #(
    .T_SU (T_SU),
    .T_EN (T_EN),
    .T_HD (T_HD)
  ) u_slot_timer (
    .LCDCLK    (LCDCLK),
    .PRESETn   (PRESETn),
    .start     (launch_c),
    .active    (slot_active),
    .en        (slot_en),
    .slot_done (slot_done)
  );

  // A new slot starts whenever a sending state finds the timer idle
  assign launch_c = !slot_active &&
                    ((state == ST_ADDR) || (state == ST_CHAR) ||
                     (INIT_EN && (state == ST_INIT)));

  assign LCD_RS   = xfer.rs;
  assign LCD_DATA = xfer.data;
  assign LCD_EN   = slot_en;
  assign LCD_RW   = 1'b0;

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= ST_INIT;
      xfer       <= '0;
      frame      <= '0;
      update_ack <= 1'b0;
      busy       <= 1'b1;
      init_idx   <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      char_idx   <= '0;
      clr_cnt    <= '0;
    end else begin
      update_ack <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (!INIT_EN) begin
            state <= ST_WAIT_REQ;
            busy  <= 1'b0;
          end else if (launch_c) begin
            xfer.rs   <= 1'b0;
            xfer.data <= INIT_CMD[init_idx];
          end else if (slot_done) begin
            if (init_idx == 2'(N_INIT_CMD - 1)) begin
              init_idx <= '0;
              clr_cnt  <= '0;
              if (T_CLR == 0) begin
                state <= ST_WAIT_REQ;
                busy  <= 1'b0;
              end else begin
                state <= ST_CLR_WAIT;
              end
            end else begin
              init_idx <= 2'(init_idx + 1'b1);
            end
          end
        end

        // Clear-display needs a long idle gap before the controller accepts more
        ST_CLR_WAIT: begin
          if (clr_cnt == CLR_W'(T_CLR - 1)) begin
            clr_cnt <= '0;
            state   <= ST_WAIT_REQ;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= CLR_W'(clr_cnt + 1'b1);
          end
        end

        ST_WAIT_REQ: begin
          if (update_req) begin
            frame      <= data;
            update_ack <= 1'b1;
            busy       <= 1'b1;
            row_idx    <= '0;
            col_idx    <= '0;
            char_idx   <= '0;
            state      <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (launch_c) begin
            xfer.rs   <= 1'b0;
            xfer.data <= row_addr_cmd(2'(row_idx));
          end else if (slot_done) begin
            col_idx <= '0;
            state   <= ST_CHAR;
          end
        end

        ST_CHAR: begin
          if (launch_c) begin
            xfer.rs   <= 1'b1;
            xfer.data <= frame[char_idx];
          end else if (slot_done) begin
            if (col_idx == COL_W'(COLS - 1)) begin
              col_idx <= '0;
              if (row_idx == ROW_W'(ROWS - 1)) begin
                row_idx  <= '0;
                char_idx <= '0;
                busy     <= 1'b0;
                state    <= ST_DONE;
              end else begin
                row_idx  <= ROW_W'(row_idx + 1'b1);
                char_idx <= IDX_W'(char_idx + 1'b1);
                state    <= ST_ADDR;
              end
            end else begin
              col_idx  <= COL_W'(col_idx + 1'b1);
              char_idx <= IDX_W'(char_idx + 1'b1);
            end
          end
        end

        // Single idle cycle between frames; refresh mode may take a new snapshot here
        ST_DONE: begin
          if (AUTO_REFRESH != 0) begin
            if (update_req) begin
              frame      <= data;
              update_ack <= 1'b1;
            end
            row_idx  <= '0;
            col_idx  <= '0;
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_ADDR;
          end else begin
            state <= ST_WAIT_REQ;
          end
        end

        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_lcd_multi.sv
// Scoreboard bench for text_lcd_multi: stimulus queues expected bus slots, a monitor checks them.
module tb_text_lcd_multi;

  localparam int unsigned COLS  = 2;
  localparam int unsigned ROWS  = 2;
  localparam int unsigned T_SU  = 2;
  localparam int unsigned T_EN  = 4;
  localparam int unsigned T_HD  = 2;
  localparam int unsigned T_CLR = 10;
  localparam int          SLOT  = 8;

  typedef logic [8:0] exp_t;  // {rs, data}

  logic        LCDCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] data = '0;
  logic        update_req = 1'b0;
  logic        update_ack;
  logic        busy;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_EN;
  logic [7:0]  LCD_DATA;

  text_lcd_multi #(
    .COLS(COLS), .ROWS(ROWS), .T_SU(T_SU), .T_EN(T_EN), .T_HD(T_HD),
    .T_CLR(T_CLR), .AUTO_REFRESH(0)
  ) dut (
    .LCDCLK(LCDCLK), .PRESETn(PRESETn), .data(data), .update_req(update_req),
    .update_ack(update_ack), .busy(busy), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
  );

  always #5 LCDCLK = ~LCDCLK;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   slots_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [31:0] d);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, d[7:0]});
    exp_q.push_back({1'b1, d[15:8]});
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, d[23:16]});
    exp_q.push_back({1'b1, d[31:24]});
  endtask

  // Monitor: one slot per EN rising edge, checked against the scoreboard queue
  logic en_prev = 1'b0;
  int   en_len = 0;
  int   cyc = 0;
  int   last_rise = -1;
  bit   after_clr = 1'b0;
  exp_t cur;
  exp_t e;

  always @(negedge LCDCLK) begin
    cyc++;
    if (!PRESETn) begin
      en_prev   = 1'b0;
      en_len    = 0;
      last_rise = -1;
      after_clr = 1'b0;
    end else begin
      if (LCD_EN && !en_prev) begin
        slots_seen++;
        cur = {LCD_RS, LCD_DATA};
        check("lcd_rw", 32'(LCD_RW), 32'd0);
        if (last_rise >= 0)
          check("slot_spacing", 32'((cyc - last_rise) >= (after_clr ? SLOT + int'(T_CLR) : SLOT)), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_slot: got rs=%0b data=0x%02h, required no slot", LCD_RS, LCD_DATA);
        end else begin
          e = exp_q.pop_front();
          check("slot_rs_data", 32'(cur), 32'(e));
        end
        after_clr = (cur == {1'b0, 8'h01});
        last_rise = cyc;
        en_len    = 1;
      end else if (LCD_EN) begin
        en_len++;
      end else if (en_prev) begin
        check("en_width", 32'(en_len), 32'(T_EN));
        check("rs_data_stable", 32'({LCD_RS, LCD_DATA}), 32'(cur));
      end
      en_prev = LCD_EN;
    end
  end

  task automatic wait_ack(output bit got, output logic busy_before);
    got = 1'b0;
    busy_before = busy;
    for (int i = 0; i < 400; i++) begin
      @(negedge LCDCLK);
      if (update_ack) begin
        got = 1'b1;
        break;
      end
      busy_before = busy;
    end
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge LCDCLK);
      if (exp_q.size() == 0 && !busy && !LCD_EN) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy, exp_q.size());
    end
  endtask

  task automatic after_reset_release();
`ifdef TEXT_LCD_INIT_SEQ_EN
    @(negedge LCDCLK);
    check("busy_in_init", 32'(busy), 32'd1);
    wait_idle();
`else
    repeat (2) @(negedge LCDCLK);
    check("busy_low_after_reset", 32'(busy), 32'd0);
`endif
  endtask

  task automatic request_frame(input logic [31:0] d);
    bit   got;
    logic bb;
    data = d;
    push_frame(d);
    update_req = 1'b1;
    wait_ack(got, bb);
    check("idle_before_ack", 32'(bb), 32'd0);
    update_req = 1'b0;
    @(negedge LCDCLK);
    check("ack_one_cycle", 32'(update_ack), 32'd0);
  endtask

  initial begin
    bit   got;
    logic bb;
    int   base;

    repeat (3) @(negedge LCDCLK);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_data", 32'(LCD_DATA), 32'h00);
    check("rst_ack", 32'(update_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

`ifdef TEXT_LCD_INIT_SEQ_EN
    push_init();
`endif
    PRESETn = 1'b1;
    after_reset_release();

    // Frame 1, then a request and data change while it is still being written
    base = slots_seen;
    request_frame(32'h44434241);
    repeat (10) @(negedge LCDCLK);
    check("busy_mid_frame", 32'(busy), 32'd1);
    data = 32'h48474645;
    push_frame(data);
    update_req = 1'b1;
    wait_ack(got, bb);
    check("ack_after_frame_done", 32'(slots_seen - base), 32'd6);
    check("busy_low_before_ack", 32'(bb), 32'd0);
    update_req = 1'b0;
    @(negedge LCDCLK);
    check("ack_one_cycle_2", 32'(update_ack), 32'd0);
    repeat (15) @(negedge LCDCLK);
    data = 32'h33323130;
    wait_idle();

    // Reset while EN is high in the first slot of a frame
    data = 32'h39383736;
    exp_q.push_back({1'b0, 8'h80});
    update_req = 1'b1;
    wait_ack(got, bb);
    update_req = 1'b0;
    for (int i = 0; i < 50 && !LCD_EN; i++) @(negedge LCDCLK);
    check("en_high_before_reset", 32'(LCD_EN), 32'd1);
    @(negedge LCDCLK);
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_en", 32'(LCD_EN), 32'd0);
    check("async_rst_rs", 32'(LCD_RS), 32'd0);
    check("async_rst_data", 32'(LCD_DATA), 32'h00);
    check("async_rst_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge LCDCLK);
`ifdef TEXT_LCD_INIT_SEQ_EN
    push_init();
`endif
    PRESETn = 1'b1;
    after_reset_release();

    request_frame(32'h34333231);
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
